// File: rtl/bsg_wormhole_flit_arbiter.sv
// Round-robin per-packet arbiter sharing one wormhole link among num_in_p flit streams.
// Grant locks on the header flit and holds for len body flits; zero-bubble pass-through.
module bsg_wormhole_flit_arbiter #(
  parameter int unsigned num_in_p     = 4,
  parameter int unsigned flit_width_p = 32,
  parameter int unsigned cord_width_p = 5,
  parameter int unsigned len_width_p  = 4,
  localparam int unsigned id_width_lp = $clog2(num_in_p)
) (
  input  logic                             clk_i,
  input  logic                             reset_i,
  input  logic [num_in_p*flit_width_p-1:0] flit_i,
  input  logic [num_in_p-1:0]              v_i,
  output logic [num_in_p-1:0]              ready_and_o,
  output logic [flit_width_p-1:0]          flit_o,
  output logic                             v_o,
  input  logic                             ready_and_i,
  output logic [id_width_lp-1:0]           grant_id_o,
  output logic                             locked_o
);

  typedef enum logic [1:0] {StIdle, StHdrWait, StBody} state_e;

  state_e                 state_q, state_d;
  logic [id_width_lp-1:0] rr_ptr_q, rr_ptr_d;
  logic [id_width_lp-1:0] held_id_q, held_id_d;
  logic [len_width_p-1:0] body_cnt_q, body_cnt_d;

  logic [id_width_lp-1:0] scan_sel, sel;
  logic                   scan_found;
  logic [len_width_p-1:0] hdr_len;
  logic                   xfer;

  function automatic logic [id_width_lp-1:0] wrap_add(input logic [id_width_lp-1:0] id,
                                                      input int unsigned off);
    return id_width_lp'((32'(id) + off) % num_in_p);
  endfunction

  // First valid input starting at rr_ptr, wrapping modulo num_in_p.
  always_comb begin
    scan_sel   = rr_ptr_q;
    scan_found = 1'b0;
    for (int unsigned i = 0; i < num_in_p; i++) begin
      if (!scan_found && v_i[wrap_add(rr_ptr_q, i)]) begin
        scan_found = 1'b1;
        scan_sel   = wrap_add(rr_ptr_q, i);
      end
    end
  end

  assign sel = (state_q == StIdle) ? scan_sel : held_id_q;

  always_comb begin
    flit_o      = '0;
    ready_and_o = '0;
    for (int unsigned k = 0; k < num_in_p; k++) begin
      if (sel == id_width_lp'(k)) begin
        flit_o         = flit_i[k*flit_width_p +: flit_width_p];
        ready_and_o[k] = ready_and_i & ~reset_i;
      end
    end
  end

  always_comb begin
    v_o = 1'b0;
    if (!reset_i) begin
      v_o = (state_q == StIdle) ? (|v_i) : v_i[held_id_q];
    end
  end

  assign grant_id_o = reset_i ? '0 : sel;
  assign locked_o   = ~reset_i & (state_q != StIdle);
  assign hdr_len    = flit_o[cord_width_p +: len_width_p];
  assign xfer       = v_o & ready_and_i;

  always_comb begin
    state_d    = state_q;
    rr_ptr_d   = rr_ptr_q;
    held_id_d  = held_id_q;
    body_cnt_d = body_cnt_q;
    unique case (state_q)
      StIdle: begin
        if (xfer) begin
          rr_ptr_d = wrap_add(sel, 1);
          if (hdr_len != '0) begin
            state_d    = StBody;
            held_id_d  = sel;
            body_cnt_d = hdr_len;
          end
        end else if (v_o) begin
          // Stalled header must stay presented even if a higher-priority input appears.
          state_d   = StHdrWait;
          held_id_d = sel;
        end
      end
      StHdrWait: begin
        if (xfer) begin
          rr_ptr_d = wrap_add(held_id_q, 1);
          if (hdr_len != '0) begin
            state_d    = StBody;
            body_cnt_d = hdr_len;
          end else begin
            state_d = StIdle;
          end
        end
      end
      StBody: begin
        if (xfer) begin
          body_cnt_d = body_cnt_q - 1'b1;
          if (body_cnt_q == len_width_p'(1)) begin
            state_d = StIdle;
          end
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q    <= StIdle;
      rr_ptr_q   <= '0;
      held_id_q  <= '0;
      body_cnt_q <= '0;
    end else begin
      state_q    <= state_d;
      rr_ptr_q   <= rr_ptr_d;
      held_id_q  <= held_id_d;
      body_cnt_q <= body_cnt_d;
    end
  end

`ifndef SYNTHESIS
  logic                    stall_q;
  logic [flit_width_p-1:0] flit_prev_q;

  always_ff @(posedge clk_i) begin
    stall_q     <= ~reset_i & v_o & ~ready_and_i;
    flit_prev_q <= flit_o;
    if (!reset_i) begin
      assert ($onehot0(ready_and_o)) else $error("ready_and_o not onehot0");
      assert (!((state_q == StHdrWait) && v_i[held_id_q]) || v_o)
        else $error("v_o dropped in header wait");
      if (stall_q) begin
        assert (flit_o == flit_prev_q) else $error("flit_o changed while stalled");
      end
    end
  end
`endif

endmodule

// File: tb/tb_bsg_wormhole_flit_arbiter.sv
// Directed self-checking bench for bsg_wormhole_flit_arbiter (4 inputs, 32-bit flits).
module tb_bsg_wormhole_flit_arbiter;

  logic         clk_i = 1'b0;
  logic         reset_i;
  logic [127:0] flit_i;
  logic [3:0]   v_i;
  logic [3:0]   ready_and_o;
  logic [31:0]  flit_o;
  logic         v_o;
  logic         ready_and_i;
  logic [1:0]   grant_id_o;
  logic         locked_o;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk_i = ~clk_i;

  bsg_wormhole_flit_arbiter #(
    .num_in_p    (4),
    .flit_width_p(32),
    .cord_width_p(5),
    .len_width_p (4)
  ) dut (
    .clk_i      (clk_i),
    .reset_i    (reset_i),
    .flit_i     (flit_i),
    .v_i        (v_i),
    .ready_and_o(ready_and_o),
    .flit_o     (flit_o),
    .v_o        (v_o),
    .ready_and_i(ready_and_i),
    .grant_id_o (grant_id_o),
    .locked_o   (locked_o)
  );

  // Header: tag in [31:24] (ignored by the arbiter), len in [8:5], cord in [4:0].
  function automatic logic [31:0] hdr(input logic [3:0] len, input logic [7:0] tag);
    return {tag, 15'h5a5a, len, 5'h13};
  endfunction

  function automatic logic [31:0] body(input int k, input int b);
    return 32'hb0d0_0000 | 32'(k << 8) | 32'(b);
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic cyc(input string tag, input logic ev, input logic [31:0] ef,
                     input logic [1:0] eg, input logic el, input logic [3:0] er);
    #1;
    chk({tag, ".v_o"}, 32'(v_o), 32'(ev));
    chk({tag, ".ready"}, 32'(ready_and_o), 32'(er));
    chk({tag, ".locked"}, 32'(locked_o), 32'(el));
    if (ev) begin
      chk({tag, ".flit"}, flit_o, ef);
      chk({tag, ".gid"}, 32'(grant_id_o), 32'(eg));
    end
  endtask

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic setf(input int k, input logic [31:0] f);
    flit_i[k*32 +: 32] = f;
  endtask

  initial begin
    reset_i     = 1'b1;
    ready_and_i = 1'b1;
    v_i         = 4'b0000;
    flit_i      = '0;
    tick();
    tick();

    // Outputs forced quiet during reset even with requests present.
    v_i = 4'b1111;
    cyc("rst", 1'b0, 32'h0, 2'd0, 1'b0, 4'b0000);
    reset_i = 1'b0;
    v_i     = 4'b0000;
    cyc("idle", 1'b0, 32'h0, 2'd0, 1'b0, 4'b0001);

    // 1: single requester, len=3.
    v_i = 4'b0001;
    setf(0, hdr(4'd3, 8'ha0));
    cyc("t1.h", 1'b1, hdr(4'd3, 8'ha0), 2'd0, 1'b0, 4'b0001);
    tick();
    for (int b = 1; b <= 3; b++) begin
      setf(0, body(0, b));
      cyc($sformatf("t1.b%0d", b), 1'b1, body(0, b), 2'd0, 1'b1, 4'b0001);
      tick();
    end
    v_i = 4'b0000;
    cyc("t1.end", 1'b0, 32'h0, 2'd0, 1'b0, 4'b0010);

    // 2: all valid with len=0 packets, from rr_ptr=0.
    reset_i = 1'b1;
    tick();
    reset_i = 1'b0;
    for (int k = 0; k < 4; k++) setf(k, hdr(4'd0, 8'(8'h20 + k)));
    v_i = 4'b1111;
    for (int n = 0; n < 5; n++) begin
      cyc($sformatf("t2.%0d", n), 1'b1, hdr(4'd0, 8'(8'h20 + (n % 4))), 2'(n % 4), 1'b0,
          4'(1 << (n % 4)));
      tick();
    end
    v_i = 4'b0000;

    // 3: in1 len=5; in0/in2 arrive with two body flits left.
    v_i = 4'b0010;
    setf(1, hdr(4'd5, 8'h31));
    cyc("t3.h", 1'b1, hdr(4'd5, 8'h31), 2'd1, 1'b0, 4'b0010);
    tick();
    for (int b = 1; b <= 5; b++) begin
      setf(1, body(1, b));
      if (b == 4) begin
        setf(0, hdr(4'd0, 8'h40));
        setf(2, hdr(4'd0, 8'h42));
        v_i = 4'b0111;
      end
      cyc($sformatf("t3.b%0d", b), 1'b1, body(1, b), 2'd1, 1'b1, 4'b0010);
      tick();
    end
    v_i = 4'b0101;
    cyc("t3.in2", 1'b1, hdr(4'd0, 8'h42), 2'd2, 1'b0, 4'b0100);
    tick();
    cyc("t3.in0", 1'b1, hdr(4'd0, 8'h40), 2'd0, 1'b0, 4'b0001);
    tick();
    v_i = 4'b0000;

    // 4: stalled in3 header holds against later in0 request.
    ready_and_i = 1'b0;
    setf(3, hdr(4'd1, 8'h53));
    v_i = 4'b1000;
    cyc("t4.stall", 1'b1, hdr(4'd1, 8'h53), 2'd3, 1'b0, 4'b0000);
    tick();
    setf(0, hdr(4'd0, 8'h60));
    v_i = 4'b1001;
    cyc("t4.wait", 1'b1, hdr(4'd1, 8'h53), 2'd3, 1'b1, 4'b0000);
    tick();
    ready_and_i = 1'b1;
    cyc("t4.go", 1'b1, hdr(4'd1, 8'h53), 2'd3, 1'b1, 4'b1000);
    tick();
    setf(3, body(3, 1));
    cyc("t4.b1", 1'b1, body(3, 1), 2'd3, 1'b1, 4'b1000);
    tick();
    v_i = 4'b0001;
    cyc("t4.in0", 1'b1, hdr(4'd0, 8'h60), 2'd0, 1'b0, 4'b0001);
    tick();
    v_i = 4'b0000;

    // 5: bubble inside in2 packet while in1 waits.
    setf(2, hdr(4'd2, 8'h72));
    v_i = 4'b0100;
    cyc("t5.h", 1'b1, hdr(4'd2, 8'h72), 2'd2, 1'b0, 4'b0100);
    tick();
    setf(2, body(2, 1));
    cyc("t5.b1", 1'b1, body(2, 1), 2'd2, 1'b1, 4'b0100);
    tick();
    setf(1, hdr(4'd0, 8'h81));
    v_i         = 4'b0010;
    ready_and_i = 1'b0;
    for (int n = 0; n < 3; n++) begin
      cyc($sformatf("t5.bub%0d", n), 1'b0, 32'h0, 2'd0, 1'b1, 4'b0000);
      tick();
    end
    ready_and_i = 1'b1;
    setf(2, body(2, 2));
    v_i = 4'b0110;
    cyc("t5.b2", 1'b1, body(2, 2), 2'd2, 1'b1, 4'b0100);
    tick();
    v_i = 4'b0010;
    cyc("t5.in1", 1'b1, hdr(4'd0, 8'h81), 2'd1, 1'b0, 4'b0010);
    tick();
    v_i = 4'b0000;

    // 6: reset mid-packet with four body flits outstanding.
    setf(2, hdr(4'd5, 8'h92));
    v_i = 4'b0100;
    cyc("t6.h", 1'b1, hdr(4'd5, 8'h92), 2'd2, 1'b0, 4'b0100);
    tick();
    setf(2, body(2, 1));
    cyc("t6.b1", 1'b1, body(2, 1), 2'd2, 1'b1, 4'b0100);
    tick();
    reset_i = 1'b1;
    v_i     = 4'b0101;
    cyc("t6.rst", 1'b0, 32'h0, 2'd0, 1'b0, 4'b0000);
    tick();
    reset_i = 1'b0;
    v_i     = 4'b0000;
    cyc("t6.idle", 1'b0, 32'h0, 2'd0, 1'b0, 4'b0001);
    for (int k = 0; k < 4; k++) setf(k, hdr(4'd0, 8'(8'ha0 + k)));
    v_i = 4'b1111;
    cyc("t6.in0", 1'b1, hdr(4'd0, 8'ha0), 2'd0, 1'b0, 4'b0001);
    tick();
    v_i = 4'b0000;
    tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
